// File: rtl/railway_uart_cmd_rx_pkg.sv
// Shared constants for the control-centre command link: packet codes and FSM state encodings.
package railway_uart_cmd_rx_pkg;

    localparam logic [7:0] SYNC_BYTE    = 8'hA5;
    localparam logic [7:0] CMD_WEATHER  = 8'h01;
    localparam logic [7:0] CMD_EMERG    = 8'h02;
    localparam logic [7:0] CMD_OVERRIDE = 8'h03;

    localparam logic [2:0] RX_IDLE  = 3'd0;
    localparam logic [2:0] RX_START = 3'd1;
    localparam logic [2:0] RX_DATA  = 3'd2;
    localparam logic [2:0] RX_STOP  = 3'd3;
    localparam logic [2:0] RX_BREAK = 3'd4;

    localparam logic [1:0] PS_WAIT_SYNC = 2'd0;
    localparam logic [1:0] PS_GET_CMD   = 2'd1;
    localparam logic [1:0] PS_GET_DATA  = 2'd2;
    localparam logic [1:0] PS_GET_CHK   = 2'd3;

    function automatic logic cmd_known(input logic [7:0] cmd);
        return (cmd == CMD_WEATHER) || (cmd == CMD_EMERG) || (cmd == CMD_OVERRIDE);
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: 2-FF synchronizer, 16x oversampling tick divider and byte FSM.
module uart_rx_byte
    import railway_uart_cmd_rx_pkg::*;
#(
    parameter int DIV = 27
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic             rx_meta;
    logic             rx_sync;
    logic             rx_prev;
    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    logic [3:0]       tick_cnt;
    logic [2:0]       bit_cnt;
    logic [2:0]       state;
    logic [7:0]       shreg;
    logic             sample;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    assign tick   = (div_cnt == DIV_W'(DIV - 1));
    assign sample = tick && (tick_cnt == 4'd15);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RX_IDLE;
            div_cnt    <= '0;
            tick_cnt   <= '0;
            bit_cnt    <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            div_cnt    <= tick ? '0 : div_cnt + 1'b1;
            if (tick)
                tick_cnt <= tick_cnt + 4'd1;
            case (state)
                RX_IDLE: begin
                    // Restart the divider so tick 8 lands mid start bit
                    if (rx_prev && !rx_sync) begin
                        state    <= RX_START;
                        tick_cnt <= '0;
                        div_cnt  <= '0;
                    end
                end
                RX_START: begin
                    if (tick && tick_cnt == 4'd7) begin
                        tick_cnt <= '0;
                        bit_cnt  <= '0;
                        state    <= rx_sync ? RX_IDLE : RX_DATA;
                    end
                end
                RX_DATA: begin
                    if (sample) begin
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7)
                            state <= RX_STOP;
                    end
                end
                RX_STOP: begin
                    if (sample) begin
                        if (rx_sync) begin
                            byte_valid <= 1'b1;
                            state      <= RX_IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= RX_BREAK;
                        end
                    end
                end
                RX_BREAK: begin
                    if (rx_sync)
                        state <= RX_IDLE;
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == RX_DATA && sample)
            shreg <= {rx_sync, shreg[7:1]};
        if (state == RX_STOP && sample)
            rx_data <= shreg;
    end

endmodule

// File: rtl/railway_uart_cmd_rx.sv
// Control-centre command receiver: packet parser, latched command registers and fail-safe link watchdog.
module railway_uart_cmd_rx
    import railway_uart_cmd_rx_pkg::*;
#(
    parameter int CLK_HZ       = 50_000_000,
    parameter int BAUD         = 115200,
    parameter int N_CROSSINGS  = 4,
    parameter int BYTE_TMO_CYC = 50_000,
    parameter int LINK_TMO_CYC = 50_000_000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   uart_rx,
    output logic                   cmd_valid,
    output logic                   cmd_emergency,
    output logic [1:0]             cmd_weather_mode,
    output logic [N_CROSSINGS-1:0] cmd_override_en,
    output logic [N_CROSSINGS-1:0] cmd_override_val,
    output logic                   link_alive,
    output logic                   frame_err,
    output logic                   pkt_err
);

    localparam int DIV_RAW = CLK_HZ / (BAUD * 16);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int BT_W    = $clog2(BYTE_TMO_CYC + 1);
    localparam int LK_W    = $clog2(LINK_TMO_CYC + 1);

    logic [7:0]      rx_byte;
    logic            byte_valid;
    logic [1:0]      pstate;
    logic [7:0]      cmd_byte;
    logic [7:0]      data_byte;
    logic [BT_W-1:0] byte_tmo;
    logic [LK_W-1:0] link_cnt;
    logic            chk_ok;
    logic            apply;
    logic            byte_timeout;
    logic            link_drop;

    uart_rx_byte #(.DIV(DIV)) u_rx_byte (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (uart_rx),
        .rx_data    (rx_byte),
        .byte_valid (byte_valid),
        .frame_err  (frame_err)
    );

    assign chk_ok       = (rx_byte == (cmd_byte ^ data_byte)) && cmd_known(cmd_byte);
    assign apply        = byte_valid && (pstate == PS_GET_CHK) && chk_ok;
    assign byte_timeout = (pstate != PS_WAIT_SYNC) && !byte_valid
                          && (byte_tmo == BT_W'(BYTE_TMO_CYC - 1));
    // A good packet in the expiry cycle keeps the link up
    assign link_drop    = link_alive && !apply && (link_cnt == LK_W'(LINK_TMO_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pstate   <= PS_WAIT_SYNC;
            byte_tmo <= '0;
            pkt_err  <= 1'b0;
        end else begin
            pkt_err  <= 1'b0;
            byte_tmo <= (pstate == PS_WAIT_SYNC || byte_valid) ? '0 : byte_tmo + 1'b1;
            if (frame_err) begin
                pstate <= PS_WAIT_SYNC;
            end else if (byte_timeout) begin
                pkt_err <= 1'b1;
                pstate  <= PS_WAIT_SYNC;
            end else if (byte_valid) begin
                case (pstate)
                    PS_WAIT_SYNC: if (rx_byte == SYNC_BYTE) pstate <= PS_GET_CMD;
                    PS_GET_CMD:   pstate <= PS_GET_DATA;
                    PS_GET_DATA:  pstate <= PS_GET_CHK;
                    default: begin
                        pstate  <= PS_WAIT_SYNC;
                        pkt_err <= !chk_ok;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (byte_valid && pstate == PS_GET_CMD)
            cmd_byte <= rx_byte;
        if (byte_valid && pstate == PS_GET_DATA)
            data_byte <= rx_byte;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_valid        <= 1'b0;
            cmd_emergency    <= 1'b0;
            cmd_weather_mode <= '0;
            cmd_override_en  <= '0;
            cmd_override_val <= '0;
        end else begin
            cmd_valid <= apply;
            if (link_drop)
                cmd_override_en <= '0;
            if (apply) begin
                case (cmd_byte)
                    CMD_WEATHER: cmd_weather_mode <= data_byte[1:0];
                    CMD_EMERG:   cmd_emergency    <= data_byte[0];
                    CMD_OVERRIDE: begin
                        cmd_override_en  <= data_byte[7:4];
                        cmd_override_val <= data_byte[3:0];
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            link_cnt   <= '0;
            link_alive <= 1'b0;
        end else if (apply) begin
            link_cnt   <= '0;
            link_alive <= 1'b1;
        end else begin
            if (link_cnt != LK_W'(LINK_TMO_CYC))
                link_cnt <= link_cnt + 1'b1;
            if (link_drop)
                link_alive <= 1'b0;
        end
    end

endmodule

// File: tb/tb_railway_uart_cmd_rx.sv
// Directed bench for railway_uart_cmd_rx with a scaled-down bit rate and timeouts.
module tb_railway_uart_cmd_rx;

    localparam int CLK_HZ   = 3_200_000;
    localparam int BAUD     = 100_000;
    localparam int BIT      = 32;
    localparam int BYTE_TMO = 1000;
    localparam int LINK_TMO = 6000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       uart_rx = 1'b1;
    logic       cmd_valid;
    logic       cmd_emergency;
    logic [1:0] cmd_weather_mode;
    logic [3:0] cmd_override_en;
    logic [3:0] cmd_override_val;
    logic       link_alive;
    logic       frame_err;
    logic       pkt_err;

    int checks = 0;
    int errors = 0;
    int cv_cnt = 0;
    int fe_cnt = 0;
    int pe_cnt = 0;

    railway_uart_cmd_rx #(
        .CLK_HZ       (CLK_HZ),
        .BAUD         (BAUD),
        .N_CROSSINGS  (4),
        .BYTE_TMO_CYC (BYTE_TMO),
        .LINK_TMO_CYC (LINK_TMO)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .uart_rx          (uart_rx),
        .cmd_valid        (cmd_valid),
        .cmd_emergency    (cmd_emergency),
        .cmd_weather_mode (cmd_weather_mode),
        .cmd_override_en  (cmd_override_en),
        .cmd_override_val (cmd_override_val),
        .link_alive       (link_alive),
        .frame_err        (frame_err),
        .pkt_err          (pkt_err)
    );

    always #5 clk = ~clk;

    // Pulse counters: a pulse longer than one cycle is counted more than once
    always @(negedge clk) begin
        if (cmd_valid) cv_cnt++;
        if (frame_err) fe_cnt++;
        if (pkt_err)   pe_cnt++;
    end

    typedef struct packed {
        logic [31:0] pkt;
        logic [1:0]  weather;
        logic        emerg;
        logic [3:0]  en;
        logic [3:0]  val;
        logic [3:0]  d_cv;
        logic [3:0]  d_pe;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        uart_rx = 1'b0;
        repeat (BIT) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (BIT) @(posedge clk);
        end
        uart_rx = stop_bit;
        repeat (BIT) @(posedge clk);
        uart_rx = 1'b1;
    endtask

    task automatic send_pkt(input logic [31:0] p);
        send_byte(p[31:24], 1'b1);
        send_byte(p[23:16], 1'b1);
        send_byte(p[15:8], 1'b1);
        send_byte(p[7:0], 1'b1);
    endtask

    initial begin
        int cv0;
        int fe0;
        int pe0;

        vecs[0] = '{32'hA5010203, 2'd2, 1'b0, 4'h0, 4'h0, 4'd1, 4'd0};
        vecs[1] = '{32'hA503F5F6, 2'd2, 1'b0, 4'hF, 4'h5, 4'd1, 4'd0};
        vecs[2] = '{32'hA5020100, 2'd2, 1'b0, 4'hF, 4'h5, 4'd0, 4'd1};
        vecs[3] = '{32'hA5020103, 2'd2, 1'b1, 4'hF, 4'h5, 4'd1, 4'd0};
        vecs[4] = '{32'hA5040004, 2'd2, 1'b1, 4'hF, 4'h5, 4'd0, 4'd1};
        vecs[5] = '{32'hA501A5A4, 2'd1, 1'b1, 4'hF, 4'h5, 4'd1, 4'd0};
        vecs[6] = '{32'hA5033C3F, 2'd1, 1'b1, 4'h3, 4'hC, 4'd1, 4'd0};
        vecs[7] = '{32'hA5020002, 2'd1, 1'b0, 4'h3, 4'hC, 4'd1, 4'd0};
        vecs[8] = '{32'hA5010302, 2'd3, 1'b0, 4'h3, 4'hC, 4'd1, 4'd0};

        repeat (5) @(posedge clk);
        @(negedge clk);
        check("rst cmd_valid", 32'(cmd_valid), 0);
        check("rst emergency", 32'(cmd_emergency), 0);
        check("rst weather", 32'(cmd_weather_mode), 0);
        check("rst override_en", 32'(cmd_override_en), 0);
        check("rst override_val", 32'(cmd_override_val), 0);
        check("rst link_alive", 32'(link_alive), 0);
        check("rst errors", 32'({frame_err, pkt_err}), 0);
        #2 rst_n = 1'b1;
        repeat (20) @(posedge clk);

        for (int i = 0; i < 9; i++) begin
            cv0 = cv_cnt; fe0 = fe_cnt; pe0 = pe_cnt;
            send_pkt(vecs[i].pkt);
            repeat (4) @(posedge clk);
            @(negedge clk);
            check($sformatf("row%0d weather", i), 32'(cmd_weather_mode), 32'(vecs[i].weather));
            check($sformatf("row%0d emergency", i), 32'(cmd_emergency), 32'(vecs[i].emerg));
            check($sformatf("row%0d override_en", i), 32'(cmd_override_en), 32'(vecs[i].en));
            check($sformatf("row%0d override_val", i), 32'(cmd_override_val), 32'(vecs[i].val));
            check($sformatf("row%0d cmd_valid pulses", i), 32'(cv_cnt - cv0), 32'(vecs[i].d_cv));
            check($sformatf("row%0d pkt_err pulses", i), 32'(pe_cnt - pe0), 32'(vecs[i].d_pe));
            check($sformatf("row%0d frame_err pulses", i), 32'(fe_cnt - fe0), 0);
            check($sformatf("row%0d link_alive", i), 32'(link_alive), 1);
        end

        // Link watchdog: alive just before expiry, lost just after
        repeat (5880) @(posedge clk);
        @(negedge clk);
        check("wd alive before tmo", 32'(link_alive), 1);
        check("wd en before tmo", 32'(cmd_override_en), 32'h3);
        repeat (200) @(posedge clk);
        @(negedge clk);
        check("wd alive after tmo", 32'(link_alive), 0);
        check("wd en cleared", 32'(cmd_override_en), 0);
        check("wd val held", 32'(cmd_override_val), 32'hC);
        check("wd weather held", 32'(cmd_weather_mode), 3);
        check("wd emergency held", 32'(cmd_emergency), 0);

        // Frame error mid-packet aborts it; the next packet decodes
        cv0 = cv_cnt; fe0 = fe_cnt; pe0 = pe_cnt;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h55, 1'b0);
        repeat (2 * BIT) @(posedge clk);
        @(negedge clk);
        check("fe frame_err pulses", 32'(fe_cnt - fe0), 1);
        check("fe pkt_err pulses", 32'(pe_cnt - pe0), 0);
        check("fe no cmd_valid", 32'(cv_cnt - cv0), 0);
        send_pkt(32'hA5010001);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("fe next weather", 32'(cmd_weather_mode), 0);
        check("fe next cmd_valid", 32'(cv_cnt - cv0), 1);
        check("fe next pkt_err", 32'(pe_cnt - pe0), 0);
        check("fe next link_alive", 32'(link_alive), 1);

        // Inter-byte timeout drops the packet; trailing bytes are discarded
        cv0 = cv_cnt; fe0 = fe_cnt; pe0 = pe_cnt;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        repeat (BYTE_TMO + 200) @(posedge clk);
        @(negedge clk);
        check("tmo pkt_err pulses", 32'(pe_cnt - pe0), 1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h03, 1'b1);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("tmo weather unchanged", 32'(cmd_weather_mode), 0);
        check("tmo no cmd_valid", 32'(cv_cnt - cv0), 0);
        check("tmo pkt_err total", 32'(pe_cnt - pe0), 1);
        check("tmo frame_err", 32'(fe_cnt - fe0), 0);

        // Short low glitch between bytes of a packet yields no byte and no error
        cv0 = cv_cnt; fe0 = fe_cnt; pe0 = pe_cnt;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        uart_rx = 1'b0;
        repeat (6) @(posedge clk);
        uart_rx = 1'b1;
        repeat (2 * BIT) @(posedge clk);
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("glitch weather", 32'(cmd_weather_mode), 1);
        check("glitch cmd_valid", 32'(cv_cnt - cv0), 1);
        check("glitch frame_err", 32'(fe_cnt - fe0), 0);
        check("glitch pkt_err", 32'(pe_cnt - pe0), 0);

        // Reset mid-packet and mid-byte clears everything asynchronously
        send_pkt(32'hA503A6A5);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("pre-rst override_en", 32'(cmd_override_en), 32'hA);
        check("pre-rst override_val", 32'(cmd_override_val), 32'h6);
        send_byte(8'hA5, 1'b1);
        uart_rx = 1'b0;
        repeat (80) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid rst weather", 32'(cmd_weather_mode), 0);
        check("mid rst override_en", 32'(cmd_override_en), 0);
        check("mid rst override_val", 32'(cmd_override_val), 0);
        check("mid rst link_alive", 32'(link_alive), 0);
        check("mid rst pulses", 32'({cmd_valid, frame_err, pkt_err}), 0);
        uart_rx = 1'b1;
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (10) @(posedge clk);
        cv0 = cv_cnt; fe0 = fe_cnt; pe0 = pe_cnt;
        send_pkt(32'hA5020103);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("post rst emergency", 32'(cmd_emergency), 1);
        check("post rst weather", 32'(cmd_weather_mode), 0);
        check("post rst cmd_valid", 32'(cv_cnt - cv0), 1);
        check("post rst link_alive", 32'(link_alive), 1);
        check("post rst errors", 32'((fe_cnt - fe0) + (pe_cnt - pe0)), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
